// File: rtl/config_pkg.sv
// Shared memory-system configuration: memory size, RISC-V load/store
// width encodings and the big-endian lane positions used by the LSU.
package config_pkg;

    // Words in the shared instruction/data memory.
    localparam int unsigned IMEMSZ = 1024;

    // Full-word access size driven on the dmem port.
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    // RISC-V funct3 encodings for loads and stores.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    // LSB position of each lane inside a word; byte 0 is the most significant.
    localparam logic [4:0] MEM_LANE_B0 = 5'd24;
    localparam logic [4:0] MEM_LANE_B1 = 5'd16;
    localparam logic [4:0] MEM_LANE_B2 = 5'd8;
    localparam logic [4:0] MEM_LANE_B3 = 5'd0;
    localparam logic [4:0] MEM_LANE_H0 = 5'd16;
    localparam logic [4:0] MEM_LANE_H2 = 5'd0;

    // Shift that brings the addressed byte lane down to bits [7:0].
    function automatic logic [4:0] byte_lane_shift(input logic [1:0] offset);
        case (offset)
            2'd0:    return MEM_LANE_B0;
            2'd1:    return MEM_LANE_B1;
            2'd2:    return MEM_LANE_B2;
            default: return MEM_LANE_B3;
        endcase
    endfunction

    // Shift that brings the addressed halfword lane down to bits [15:0].
    function automatic logic [4:0] half_lane_shift(input logic offset_hi);
        return offset_hi ? MEM_LANE_H2 : MEM_LANE_H0;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Bus bundles around the LSU: the core-side request/response channel and
// the word-oriented dmem port towards the shared memory.

// Core <-> LSU request/response channel. The core is the master.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// LSU <-> memory port. The LSU is the master.
interface dmem_if;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        read_en;
    logic        write_en;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        fault;

    modport master (
        output addr, size, read_en, write_en, write_data,
        input  read_data, ready, fault
    );

    modport slave (
        input  addr, size, read_en, write_en, write_data,
        output read_data, ready, fault
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling for the LSU: extracts and extends the
// addressed lane of a read word for loads, and merges store data into
// the addressed lane of a read word for sub-word stores.
module lsu_lane_align
    import config_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_word_o
);

    logic [4:0]  b_shift;
    logic [4:0]  h_shift;
    logic [31:0] b_word;
    logic [31:0] h_word;
    logic [7:0]  b_lane;
    logic [15:0] h_lane;

    // Lane select, extension and merge, all driven from the lane shift.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        load_data_o   = rd_word_i;
        merged_word_o = wdata_i;

        b_shift = byte_lane_shift(offset_i);
        h_shift = half_lane_shift(offset_i[1]);
        b_word  = rd_word_i >> b_shift;
        h_word  = rd_word_i >> h_shift;
        b_lane  = b_word[7:0];
        h_lane  = h_word[15:0];

        case (op_i)
            MEM_B: begin
                load_data_o   = {{24{b_lane[7]}}, b_lane};
                merged_word_o = (rd_word_i & ~(32'h0000_00FF << b_shift))
                              | ({24'h0, wdata_i[7:0]} << b_shift);
            end
            MEM_BU: load_data_o = {24'h0, b_lane};
            MEM_H: begin
                load_data_o   = {{16{h_lane[15]}}, h_lane};
                merged_word_o = (rd_word_i & ~(32'h0000_FFFF << h_shift))
                              | ({16'h0, wdata_i[15:0]} << h_shift);
            end
            MEM_HU: load_data_o = {16'h0, h_lane};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: accepts one load or store at a time from the core and
// turns it into full-word accesses on the dmem port. Sub-word stores are
// done as read-modify-write; misaligned, out-of-range and faulted accesses
// come back to the core with resp_err set.
module dmem_lsu
    import config_pkg::*;
#(
    parameter int unsigned MEM_WORDS = config_pkg::IMEMSZ
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    dmem_if.master    dmem
);

    // The lane merge of a sub-word store happens on the RWAIT->WR edge,
    // straight from the incoming read word, so the write strobe issues in
    // the cycle right after the read data arrives.
    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        WDONE,
        RESP,
        ERR
    } state_e;

    state_e      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        rd_en_q;
    logic        wr_en_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_out_q;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] store_q;
    logic        rmw_q;

    logic        op_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_bad;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    // Classify the incoming request before it is accepted.
    always_comb begin
        case (req.req_op)
            MEM_B, MEM_H, MEM_W: op_legal = 1'b1;
            MEM_BU, MEM_HU:      op_legal = !req.req_we;
            default:             op_legal = 1'b0;
        endcase
        misaligned   = ((req.req_op == MEM_H || req.req_op == MEM_HU) && req.req_addr[0])
                    || (req.req_op == MEM_W && req.req_addr[1:0] != 2'b00);
        out_of_range = {2'b00, req.req_addr[31:2]} >= MEM_WORDS;
        req_bad      = !op_legal || misaligned || out_of_range;
    end

    lsu_lane_align u_lane_align (
        .op_i          (op_q),
        .offset_i      (off_q),
        .rd_word_i     (dmem.read_data),
        .wdata_i       (store_q),
        .load_data_o   (load_data),
        .merged_word_o (merged_word)
    );

    // Access sequencer with registered handshake, response and strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            wdata_out_q  <= '0;
            op_q         <= '0;
            off_q        <= '0;
            store_q      <= '0;
            rmw_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the pre-edge values.
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req.req_valid) begin
                        req_ready_q  <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        op_q         <= req.req_op;
                        off_q        <= req.req_addr[1:0];
                        store_q      <= req.req_wdata;
                        addr_q       <= {req.req_addr[31:2], 2'b00};
                        rmw_q        <= 1'b0;
                        if (req_bad) begin
                            state_q <= ERR;
                        end else if (!req.req_we) begin
                            state_q <= RD;
                            rd_en_q <= 1'b1;
                        end else if (req.req_op == MEM_W) begin
                            state_q     <= WR;
                            wr_en_q     <= 1'b1;
                            wdata_out_q <= req.req_wdata;
                        end else begin
                            state_q <= RD;
                            rd_en_q <= 1'b1;
                            rmw_q   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (dmem.ready) begin
                        rd_en_q <= 1'b0;
                        state_q <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (dmem.fault) begin
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (rmw_q) begin
                        wdata_out_q <= merged_word;
                        wr_en_q     <= 1'b1;
                        state_q     <= WR;
                    end else begin
                        resp_rdata_q <= load_data;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WR: begin
                    if (dmem.ready) begin
                        wr_en_q <= 1'b0;
                        state_q <= WDONE;
                    end
                end
                WDONE: begin
                    resp_err_q   <= dmem.fault;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                ERR: begin
                    resp_err_q   <= 1'b1;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rd_en_q     <= 1'b0;
                    wr_en_q     <= 1'b0;
                end
            endcase
        end
    end

    assign req.req_ready   = req_ready_q;
    assign req.resp_valid  = resp_valid_q;
    assign req.resp_err    = resp_err_q;
    assign req.resp_rdata  = resp_rdata_q;
    assign dmem.addr       = addr_q;
    assign dmem.size       = MEM_SIZE_WORD;
    assign dmem.read_en    = rd_en_q;
    assign dmem.write_en   = wr_en_q;
    assign dmem.write_data = wdata_out_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: a behavioural memory on the dmem port,
// directed cases for the documented scenarios, then randomized accesses
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_dmem_lsu;
    import config_pkg::*;

    localparam int unsigned MW = config_pkg::IMEMSZ;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_req_if req_bus ();
    dmem_if    mem_bus ();

    dmem_lsu #(.MEM_WORDS(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_bus),
        .dmem  (mem_bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural memory state (owned by the memory process).
    logic [31:0] tb_mem [MW];
    bit          init_done = 1'b0;
    logic [31:0] rdata_r = '0;
    logic        fault_r = 1'b0;
    int          rd_held = 0;
    int          wr_held = 0;
    int          n_rd = 0, n_wr = 0, n_rd_cyc = 0, n_overlap = 0, n_misal = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic        mem_ready;
    int          word_idx;

    // Memory configuration and preload port (owned by the stimulus process).
    bit          fault_rd_cfg = 1'b0, fault_wr_cfg = 1'b0;
    int          stall_rd_cfg = 0, stall_wr_cfg = 0;
    bit          pl_en = 1'b0;
    int          pl_idx = 0;
    logic [31:0] pl_val = '0;

    logic [31:0] ref_mem [MW];
    logic [2:0]  ld_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  st_ops [3] = '{3'd0, 3'd1, 3'd2};

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    assign word_idx  = int'(mem_bus.addr[31:2]);
    assign mem_ready = !((mem_bus.read_en && rd_held < stall_rd_cfg)
                      || (mem_bus.write_en && wr_held < stall_wr_cfg));
    assign mem_bus.read_data = rdata_r;
    assign mem_bus.ready     = mem_ready;
    assign mem_bus.fault     = fault_r;

    always @(posedge clk) begin
        fault_r <= 1'b0;
        if (!init_done) begin
            for (int i = 0; i < int'(MW); i++) tb_mem[i] <= init_word(i);
            init_done <= 1'b1;
        end
        if (pl_en) tb_mem[pl_idx] <= pl_val;
        if (!rst_n) begin
            rd_held <= 0;
            wr_held <= 0;
        end else begin
            if (mem_bus.read_en && mem_bus.write_en) n_overlap <= n_overlap + 1;
            if (mem_bus.read_en) begin
                n_rd_cyc <= n_rd_cyc + 1;
                if (mem_ready) begin
                    n_rd      <= n_rd + 1;
                    rd_held   <= 0;
                    last_addr <= mem_bus.addr;
                    if (mem_bus.addr[1:0] != 2'b00) n_misal <= n_misal + 1;
                    rdata_r   <= (word_idx < int'(MW)) ? tb_mem[word_idx] : 32'h0;
                    fault_r   <= fault_rd_cfg;
                end else begin
                    rd_held <= rd_held + 1;
                end
            end
            if (mem_bus.write_en) begin
                if (mem_ready) begin
                    n_wr       <= n_wr + 1;
                    wr_held    <= 0;
                    last_addr  <= mem_bus.addr;
                    last_wdata <= mem_bus.write_data;
                    if (mem_bus.addr[1:0] != 2'b00) n_misal <= n_misal + 1;
                    if (word_idx < int'(MW)) tb_mem[word_idx] <= mem_bus.write_data;
                    fault_r    <= fault_wr_cfg;
                end else begin
                    wr_held <= wr_held + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one access, straight from the load/store rules.
    task automatic model(input bit we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit f_rd, input bit f_wr,
                         input int s_rd, input int s_wr,
                         output bit err, output logic [31:0] rdata,
                         output int nrd, output int nwr, output int lat);
        int          idx;
        int          k;
        bit          legal, mis;
        logic [31:0] word, mask, ins;
        logic [7:0]  b;
        logic [15:0] h;
        idx = int'(addr[31:2]);
        k   = int'(addr[1:0]);
        err = 1'b0; rdata = '0; nrd = 0; nwr = 0; lat = 2;
        legal = we ? (op inside {3'd0, 3'd1, 3'd2}) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = ((op == 3'd1 || op == 3'd5) && addr[0]) || (op == 3'd2 && k != 0);
        if (!legal || mis || addr[31:2] >= 30'(MW)) begin
            err = 1'b1;
            return;
        end
        word = ref_mem[idx];
        b    = 8'(word >> (8 * (3 - k)));
        h    = 16'(word >> (16 * (1 - k / 2)));
        if (!we) begin
            nrd = 1;
            lat = 3 + s_rd;
            if (f_rd) begin
                err = 1'b1;
            end else begin
                case (op)
                    3'd0:    rdata = {{24{b[7]}}, b};
                    3'd4:    rdata = {24'h0, b};
                    3'd1:    rdata = {{16{h[15]}}, h};
                    3'd5:    rdata = {16'h0, h};
                    default: rdata = word;
                endcase
            end
        end else if (op == 3'd2) begin
            nwr = 1;
            lat = 3 + s_wr;
            ref_mem[idx] = wdata;
            err = f_wr;
        end else begin
            nrd = 1;
            if (f_rd) begin
                err = 1'b1;
                lat = 3 + s_rd;
            end else begin
                nwr = 1;
                lat = 5 + s_rd + s_wr;
                if (op == 3'd0) begin
                    mask = 32'hFF << (8 * (3 - k));
                    ins  = (wdata & 32'hFF) << (8 * (3 - k));
                end else begin
                    mask = 32'hFFFF << (16 * (1 - k / 2));
                    ins  = (wdata & 32'hFFFF) << (16 * (1 - k / 2));
                end
                ref_mem[idx] = (word & ~mask) | ins;
                err = f_wr;
            end
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        ref_mem[idx] = val;
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Run one access from a negedge and compare it against the model.
    task automatic do_access(input bit we, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit f_rd, input bit f_wr,
                             input int s_rd, input int s_wr, input string tag,
                             output bit got_err, output logic [31:0] got_rdata);
        bit          e_err;
        logic [31:0] e_rdata;
        int          e_nrd, e_nwr, e_lat, lat, wait_cnt;
        int          rd0, wr0, ov0, mis0;
        model(we, op, addr, wdata, f_rd, f_wr, s_rd, s_wr, e_err, e_rdata, e_nrd, e_nwr, e_lat);
        fault_rd_cfg = f_rd;
        fault_wr_cfg = f_wr;
        stall_rd_cfg = s_rd;
        stall_wr_cfg = s_wr;
        wait_cnt = 0;
        while (!req_bus.req_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check({tag, "_ready_in"}, 32'(req_bus.req_ready), 32'd1);
        rd0 = n_rd; wr0 = n_wr; ov0 = n_overlap; mis0 = n_misal;
        req_bus.req_valid = 1'b1;
        req_bus.req_we    = we;
        req_bus.req_op    = op;
        req_bus.req_addr  = addr;
        req_bus.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        lat = 1;
        while (!req_bus.resp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        got_err   = req_bus.resp_err;
        got_rdata = req_bus.resp_rdata;
        check({tag, "_latency"}, 32'(lat), 32'(e_lat));
        check({tag, "_err"}, 32'(got_err), 32'(e_err));
        check({tag, "_rdata"}, got_rdata, e_rdata);
        check({tag, "_reads"}, 32'(n_rd - rd0), 32'(e_nrd));
        check({tag, "_writes"}, 32'(n_wr - wr0), 32'(e_nwr));
        check({tag, "_overlap"}, 32'(n_overlap - ov0), 32'd0);
        check({tag, "_misal_strobe"}, 32'(n_misal - mis0), 32'd0);
        if (e_nrd + e_nwr > 0) check({tag, "_addr"}, last_addr, {addr[31:2], 2'b00});
        @(negedge clk);
        check({tag, "_pulse"}, 32'(req_bus.resp_valid), 32'd0);
        check({tag, "_ready_out"}, 32'(req_bus.req_ready), 32'd1);
        if (addr[31:2] < 30'(MW)) begin
            check({tag, "_mem"}, tb_mem[int'(addr[31:2])], ref_mem[int'(addr[31:2])]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          e;
        logic [31:0] d;
        bit          we, fr, fw;
        logic [2:0]  op;
        logic [31:0] addr, wdata;
        int          rd0, wr0, cyc0;

        req_bus.req_valid = 1'b0;
        req_bus.req_we    = 1'b0;
        req_bus.req_op    = '0;
        req_bus.req_addr  = '0;
        req_bus.req_wdata = '0;
        for (int i = 0; i < int'(MW); i++) ref_mem[i] = init_word(i);

        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        check("rst_req_ready", 32'(req_bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(req_bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(req_bus.resp_err), 32'd0);
        check("rst_resp_rdata", req_bus.resp_rdata, 32'd0);
        check("rst_read_en", 32'(mem_bus.read_en), 32'd0);
        check("rst_write_en", 32'(mem_bus.write_en), 32'd0);
        check("rst_dmem_addr", mem_bus.addr, 32'd0);
        check("rst_write_data", mem_bus.write_data, 32'd0);
        check("rst_dmem_size", 32'(mem_bus.size), 32'd2);

        // Documented load/store examples.
        preload(32'h40, 32'h1280_3456);
        do_access(1'b0, 3'd0, 32'h0000_0101, 32'h0, 1'b0, 1'b0, 0, 0, "lb", e, d);
        check("lb_value", d, 32'hFFFF_FF80);
        preload(32'h40, 32'hAAAA_BEEF);
        do_access(1'b0, 3'd5, 32'h0000_0102, 32'h0, 1'b0, 1'b0, 0, 0, "lhu", e, d);
        check("lhu_value", d, 32'h0000_BEEF);
        preload(32'h40, 32'h8001_0000);
        do_access(1'b0, 3'd1, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 0, 0, "lh", e, d);
        check("lh_value", d, 32'hFFFF_8001);
        preload(32'h80, 32'h1122_3344);
        do_access(1'b1, 3'd0, 32'h0000_0203, 32'h0000_005A, 1'b0, 1'b0, 0, 0, "sb", e, d);
        check("sb_wdata", last_wdata, 32'h1122_335A);
        check("sb_err", 32'(e), 32'd0);

        // Rejected accesses.
        do_access(1'b0, 3'd2, 32'h0000_0102, 32'h0, 1'b0, 1'b0, 0, 0, "lw_mis", e, d);
        check("lw_mis_value", 32'(e), 32'd1);
        do_access(1'b1, 3'd1, 32'h0000_0101, 32'h1234, 1'b0, 1'b0, 0, 0, "sh_mis", e, d);
        check("sh_mis_value", 32'(e), 32'd1);
        do_access(1'b0, 3'd2, MW << 2, 32'h0, 1'b0, 1'b0, 0, 0, "lw_oor", e, d);
        check("lw_oor_value", 32'(e), 32'd1);
        do_access(1'b1, 3'd4, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 0, 0, "sbu_ill", e, d);

        // Fault on the read half of a sub-word store suppresses the write.
        do_access(1'b1, 3'd0, 32'h0000_0205, 32'h0000_00C3, 1'b1, 1'b0, 0, 0, "sb_fault", e, d);
        check("sb_fault_value", 32'(e), 32'd1);

        // Memory holding off the read for three cycles.
        cyc0 = n_rd_cyc;
        do_access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 3, 0, "lw_stall", e, d);
        check("lw_stall_rd_cycles", 32'(n_rd_cyc - cyc0), 32'd4);

        // Reset during the read-modify-write of a halfword store.
        preload(32'hC0, 32'hDEAD_BEEF);
        rd0 = n_rd; wr0 = n_wr;
        fault_rd_cfg = 1'b0; fault_wr_cfg = 1'b0; stall_rd_cfg = 0; stall_wr_cfg = 0;
        req_bus.req_valid = 1'b1;
        req_bus.req_we    = 1'b1;
        req_bus.req_op    = 3'd1;
        req_bus.req_addr  = 32'h0000_0300;
        req_bus.req_wdata = 32'h0000_7777;
        @(posedge clk);
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rstmid_resp_valid", 32'(req_bus.resp_valid), 32'd0);
            check("rstmid_req_ready", 32'(req_bus.req_ready), 32'd1);
            @(negedge clk);
        end
        check("rstmid_reads", 32'(n_rd - rd0), 32'd1);
        check("rstmid_writes", 32'(n_wr - wr0), 32'd0);
        check("rstmid_mem", tb_mem[32'hC0], 32'hDEAD_BEEF);

        // Randomized accesses against the reference model.
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            op = we ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 15) == 0) op = 3'($urandom_range(0, 7));
            addr = {30'(32'h80 + $urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 19) == 0) addr[31:2] = 30'(MW + $urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) addr = $urandom();
            wdata = $urandom();
            fr = ($urandom_range(0, 9) == 0);
            fw = ($urandom_range(0, 9) == 0);
            do_access(we, op, addr, wdata, fr, fw, $urandom_range(0, 2),
                      $urandom_range(0, 2), "rnd", e, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
